hex_keypad_scanner: RTL
=======================

# hex_keypad_scanner

Scans a 4x4 matrix hex keypad using the same column-multiplexed, clock-divided timing that drives the four-digit seven-segment display, and turns debounced key presses into hex digits. Each accepted key is shifted into a 16-bit entry register. That register feeds the display driver's 16-bit input and the function generator's parameter registers, so a user can type a four-digit hex value and see it echoed.

## Interface
- scan_ratio, default 100: column dwell is scan_ratio+1 clk cycles; must be >= 2.
- debounce_count, default 4: consecutive consistent scan frames needed to accept a press or a release; range 1..15.

- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows, active-low (external pull-ups); asynchronous to clk.
- clr  input  1  synchronous clear of value.
- col  output 4  column drive, active-low one-hot, registered.
- key_code  output 4  code of the last accepted key: 4*row_index + col_index.
- key_valid  output 1  one-cycle pulse per accepted press.
- key_held  output 1  high while the accepted key is considered down.
- value  output 16  entered digits; newest digit in [3:0].

## Operation
- Row synchronizer: row passes through a 2-flop synchronizer. The design uses only the synchronized rows.
- Divider: div_count runs 0..scan_ratio, then returns to 0.
  - When it wraps, the column index advances 0→1→2→3→0.
  - col: index 0 = 4'b1110, 1 = 4'b1101, 2 = 4'b1011, 3 = 4'b0111.
- Sampling: synchronized rows are sampled on the cycle where div_count == scan_ratio, i.e. the last cycle of each dwell.
  - A low row r in column c marks key 4r+c as pressed.
- Frame: four dwells, columns 0..3. The frame result is evaluated at the column-3 sample:
  - NONE: zero keys pressed.
  - SINGLE(k): exactly one key pressed.
  - MULTI: two or more keys pressed.
- Debounce FSM: state, cand[3:0], cnt[3:0]. Transitions happen only on frame-end cycles.
  - IDLE
    - SINGLE(k) → PRESS_CHK with cand=k, cnt=1; if debounce_count==1, accept immediately.
    - NONE or MULTI → stay in IDLE.
  - PRESS_CHK
    - SINGLE(cand) → cnt+1; when the count reaches debounce_count, accept and go to HELD.
    - SINGLE(k≠cand) → stay in PRESS_CHK with cand=k, cnt=1.
    - NONE or MULTI → IDLE.
  - HELD
    - NONE → RELEASE_CHK with cnt=1; if debounce_count==1, go to IDLE.
    - SINGLE or MULTI → stay in HELD. There is no auto-repeat.
  - RELEASE_CHK
    - NONE → cnt+1; when the count reaches debounce_count, go to IDLE.
    - SINGLE or MULTI → HELD.
- Accept action: key_valid=1 for one cycle, key_code=cand, value={value[11:0], cand}. The oldest digit is discarded.
- key_held = 1 in HELD and RELEASE_CHK.
- clr: sets value=0. If it coincides with an accept, value={12'h000, cand}. clr has no effect on the FSM, key_code or the scan.

## Timing
- Reset (rst low, asynchronous) sets:
  - col=4'b1110, div_count=0
  - FSM state IDLE, cand=0, cnt=0
  - key_code=0, key_valid=0, key_held=0, value=16'h0000
  - synchronizer flops to 4'b1111
- Outputs are stable from the first rising edge after rst deasserts.
- Dwell is scan_ratio+1 cycles; frame F = 4*(scan_ratio+1) cycles.
- col changes on the edge after the last cycle of a dwell, so every sample sees rows settled for at least scan_ratio-1 cycles after synchronizer latency.
- Accept: key_valid, key_code, value and key_held all update on the same edge, the one ending the debounce_count-th consistent frame. key_valid drops on the next edge.
- Minimum press-to-valid latency: debounce_count frames, up to one extra frame depending on press phase.
- Release is seen debounce_count frames after the key opens.
- Reset mid-operation aborts any debounce. A key still held after reset is accepted again after debounce_count frames.

## Test plan
Use scan_ratio=3 and debounce_count=4, giving 4-cycle dwells and F=16.

- Reset and scan
  - Stimulus: hold rst low, release it, all rows high.
  - Required: all outputs zero; col cycles 1110, 1101, 1011, 0111, each for 4 cycles, then repeats.
- Clean press
  - Stimulus: row1 pulled low only while col==1011, held for 10 frames.
  - Required: exactly one key_valid pulse, key_code=6, value=16'h0006; key_held=1 until 4 NONE frames after release.
- Bounce rejection
  - Stimulus: key 6 alternates pressed and released every frame for 6 frames, then released.
  - Required: key_valid never asserts; value stays 0.
- Digit entry with wrap
  - Stimulus: press and release keys 1, 2, 3, 4, 5 in turn.
  - Required: five pulses; value reads 0x0001, 0x0012, 0x0123, 0x1234, then 0x2345.
- MULTI and clr
  - Stimulus: keys 0 and 5 pressed together from IDLE for 8 frames; then clr asserted on the accept edge of key A.
  - Required: no key_valid during the MULTI frames; after the accept, value=16'h000A.
- Reset mid-HELD
  - Stimulus: drop rst while key 9 is held, then release rst with key 9 still pressed.
  - Required: immediately key_held=0 and value=0; a new key_valid with key_code=9 after 4 frames.

Source files
------------

// File: rtl/hex_keypad_scanner_if.sv
// Keypad-side and entry-side signals of the hex keypad scanner.
// The slave modport is the scanner; the master modport is the keypad and its consumer.
interface hex_keypad_scanner_if;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] value;

  modport slave (
    input  row,
    input  clr,
    output col,
    output key_code,
    output key_valid,
    output key_held,
    output value
  );

  modport master (
    output row,
    output clr,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  value
  );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner with frame-based debounce and a 16-bit digit entry register.
// Columns dwell SCAN_RATIO+1 cycles; a frame is four dwells, judged at the column-3 sample.
module hex_keypad_scanner #(
  parameter int unsigned SCAN_RATIO     = 100,
  parameter int unsigned DEBOUNCE_COUNT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  hex_keypad_scanner_if.slave  kp
);
  localparam int unsigned DIV_W = $clog2(SCAN_RATIO + 1);
  localparam logic [3:0]  DB    = 4'(DEBOUNCE_COUNT);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      acc_q, acc_d;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [15:0]      value_q, value_d;

  logic        sample, frame_end;
  logic [15:0] col_bits, frame_keys;
  logic [4:0]  n_keys;
  logic [3:0]  k_idx;
  logic        none, single;
  logic [3:0]  cnt_inc;
  logic        accept;
  logic [3:0]  accept_code;

  assign sample    = (div_q == DIV_W'(SCAN_RATIO));
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign cnt_inc   = cnt_q + 4'd1;

  // Scan divider, column rotation and per-frame key accumulation
  always_comb begin
    div_d     = div_q + DIV_W'(1);
    col_idx_d = col_idx_q;
    col_d     = col_q;
    acc_d     = acc_q;
    col_bits  = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      col_bits[{2'(r), col_idx_q}] = ~row_s2_q[r];
    end
    frame_keys = acc_q | col_bits;
    if (sample) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = {col_q[2:0], col_q[3]};
      acc_d     = ((col_idx_q == 2'd0) ? 16'h0000 : acc_q) | col_bits;
    end
  end

  always_comb begin
    n_keys = '0;
    k_idx  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (frame_keys[i]) begin
        n_keys = n_keys + 5'd1;
        k_idx  = 4'(i);
      end
    end
    none   = (n_keys == 5'd0);
    single = (n_keys == 5'd1);
  end

  // Debounce FSM; only frame-end cycles can move it
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    accept_code = cand_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (single) begin
            cand_d = k_idx;
            cnt_d  = 4'd1;
            if (DB == 4'd1) begin
              accept      = 1'b1;
              accept_code = k_idx;
              state_d     = HELD;
            end else begin
              state_d = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (single && (k_idx == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else if (single) begin
            cand_d = k_idx;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (none) begin
            cnt_d   = 4'd1;
            state_d = (DB == 4'd1) ? IDLE : RELEASE_CHK;
          end
        end
        RELEASE_CHK: begin
          if (none) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? accept_code : key_code_q;
    value_d     = value_q;
    if (kp.clr) begin
      value_d = accept ? {12'h000, accept_code} : 16'h0000;
    end else if (accept) begin
      value_d = {value_q[11:0], accept_code};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_s1_q    <= 4'b1111;
      row_s2_q    <= 4'b1111;
      div_q       <= '0;
      col_idx_q   <= '0;
      col_q       <= 4'b1110;
      acc_q       <= '0;
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      value_q     <= '0;
    end else begin
      row_s1_q    <= kp.row;
      row_s2_q    <= row_s1_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      value_q     <= value_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == HELD) || (state_q == RELEASE_CHK);
  assign kp.value     = value_q;
endmodule
